// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/writeback/issue bundle for the scoreboarded register file
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   A_addr;
  logic [AW-1:0]   B_addr;
  logic [XLEN-1:0] A_data;
  logic [XLEN-1:0] B_data;
  logic            wreg;
  logic [AW-1:0]   W_addr;
  logic [XLEN-1:0] Data;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            A_busy;
  logic            B_busy;
  logic            stall;
  logic            ready;

  // pipeline side: drives addresses, writeback and issue; consumes data and status
  modport master (
    output A_addr, B_addr, wreg, W_addr, Data, issue_en, issue_addr,
    input  A_data, B_data, A_busy, B_busy, stall, ready
  );

  // register file side
  modport slave (
    input  A_addr, B_addr, wreg, W_addr, Data, issue_en, issue_addr,
    output A_data, B_data, A_busy, B_busy, stall, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R1W register file with bypass, pending-write scoreboard and sequenced clear
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  regfile_sb_if.slave  bus
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [NREG-1:0]  busy_q, busy_d;

  // Array has no reset so it can map onto RAM; the clear sequence zeroes it instead.
  logic [XLEN-1:0]  mem [NREG];

  logic             ready;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [XLEN-1:0]  mem_wdata;

  logic             wr_hit;
  logic             iss_hit;
  logic             fwd_a;
  logic             fwd_b;

  // Writeback and issue only take effect once the file is usable; address 0 is never a target.
  assign wr_hit  = ready && bus.wreg && (bus.W_addr != '0);
  assign iss_hit = ready && bus.issue_en && (bus.issue_addr != '0);

  // State register: reset restarts the clear walk at index 1 and drops all pending writes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= AW'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: walk the clear pointer to NREG-1, then update scoreboard bits in RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(NREG - 1)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        // Clear first so a same-cycle issue to the same register leaves it pending.
        if (wr_hit) begin
          busy_d[bus.W_addr] = 1'b0;
        end
        if (iss_hit) begin
          busy_d[bus.issue_addr] = 1'b1;
        end
      end
    endcase
    busy_d[0] = 1'b0;
  end

  // Outputs: single array write port shared between the clear walk and writeback.
  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we = !RESET;
      end
      default: begin
        ready     = 1'b1;
        mem_we    = !RESET && bus.wreg && (bus.W_addr != '0);
        mem_waddr = bus.W_addr;
        mem_wdata = bus.Data;
      end
    endcase
  end

  // Array write.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign fwd_a = (BYPASS != 0) && wr_hit && (bus.W_addr == bus.A_addr);
  assign fwd_b = (BYPASS != 0) && wr_hit && (bus.W_addr == bus.B_addr);

  assign bus.A_data = (!ready || bus.A_addr == '0) ? '0 :
                      fwd_a ? bus.Data : mem[bus.A_addr];
  assign bus.B_data = (!ready || bus.B_addr == '0) ? '0 :
                      fwd_b ? bus.Data : mem[bus.B_addr];

  // A forwarded operand is available this cycle, so it no longer counts as pending.
  assign bus.A_busy = fwd_a ? 1'b0 : busy_q[bus.A_addr];
  assign bus.B_busy = fwd_b ? 1'b0 : busy_q[bus.B_addr];
  assign bus.stall  = !ready || bus.A_busy || bus.B_busy;
  assign bus.ready  = ready;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed scoreboard bench for regfile_sb with and without bypass
module tb_regfile_sb;

  logic CLK;
  logic RESET;

  regfile_sb_if #(.XLEN(32), .AW(5)) bus1 ();
  regfile_sb_if #(.XLEN(32), .AW(5)) bus0 ();

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus0)
  );

  // The no-bypass instance sees exactly the same stimulus.
  assign bus0.A_addr     = bus1.A_addr;
  assign bus0.B_addr     = bus1.B_addr;
  assign bus0.wreg       = bus1.wreg;
  assign bus0.W_addr     = bus1.W_addr;
  assign bus0.Data       = bus1.Data;
  assign bus0.issue_en   = bus1.issue_en;
  assign bus0.issue_addr = bus1.issue_addr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc;
  int   stall_bad;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus1.wreg     = 1'b0;
    bus1.issue_en = 1'b0;
  endtask

  // Counts sampled cycles with ready low after RESET drops; bounded.
  task automatic wait_ready(output int n, output int sbad);
    n    = 0;
    sbad = 0;
    forever begin
      @(negedge CLK);
      if (bus1.ready === 1'b1) break;
      n++;
      if (bus1.stall !== 1'b1) sbad++;
      if (n > 200) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET           = 1'b1;
    bus1.A_addr     = '0;
    bus1.B_addr     = '0;
    bus1.W_addr     = '0;
    bus1.Data       = '0;
    bus1.issue_addr = '0;
    idle();
    tick();
    tick();

    // Reset values
    bus1.A_addr = 5'd3;
    bus1.B_addr = 5'd4;
    sb_push("rst_ready", 32'd0);
    sb_push("rst_stall", 32'd1);
    sb_push("rst_a_busy", 32'd0);
    sb_push("rst_b_busy", 32'd0);
    sb_push("rst_a_data", 32'd0);
    sb_push("rst_b_data", 32'd0);
    @(negedge CLK);
    sb_check(32'(bus1.ready));
    sb_check(32'(bus1.stall));
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus1.B_busy));
    sb_check(bus1.A_data);
    sb_check(bus1.B_data);
    tick();

    // Clear timing
    RESET = 1'b0;
    sb_push("clr_cycles", 32'd31);
    sb_push("clr_stall", 32'd0);
    sb_push("clr_ready_nobyp", 32'd1);
    wait_ready(cyc, stall_bad);
    sb_check(32'(cyc));
    sb_check(32'(stall_bad));
    sb_check(32'(bus0.ready));
    tick();

    // Every register reads zero after clear
    for (int i = 0; i < 32; i++) begin
      bus1.A_addr = 5'(i);
      bus1.B_addr = 5'(31 - i);
      sb_push($sformatf("clr_a%0d", i), 32'd0);
      sb_push($sformatf("clr_b%0d", 31 - i), 32'd0);
      @(negedge CLK);
      sb_check(bus1.A_data);
      sb_check(bus1.B_data);
      tick();
    end

    // Write x5, read it back next cycle
    bus1.wreg   = 1'b1;
    bus1.W_addr = 5'd5;
    bus1.Data   = 32'hDEADBEEF;
    tick();
    idle();
    bus1.A_addr = 5'd5;
    bus1.B_addr = 5'd0;
    sb_push("wr_x5_a", 32'hDEADBEEF);
    sb_push("wr_x5_b0", 32'd0);
    sb_push("wr_x5_stall", 32'd0);
    @(negedge CLK);
    sb_check(bus1.A_data);
    sb_check(bus1.B_data);
    sb_check(32'(bus1.stall));
    tick();

    // Write x0 is discarded, also not forwarded
    bus1.wreg   = 1'b1;
    bus1.W_addr = 5'd0;
    bus1.Data   = 32'h00001234;
    bus1.A_addr = 5'd0;
    sb_push("x0_same_cycle", 32'd0);
    @(negedge CLK);
    sb_check(bus1.A_data);
    tick();
    idle();
    sb_push("x0_after", 32'd0);
    @(negedge CLK);
    sb_check(bus1.A_data);
    tick();

    // Bypass vs no bypass on x7 with a pending write
    bus1.wreg       = 1'b1;
    bus1.W_addr     = 5'd7;
    bus1.Data       = 32'h11111111;
    tick();
    idle();
    bus1.issue_en   = 1'b1;
    bus1.issue_addr = 5'd7;
    tick();
    idle();
    bus1.wreg   = 1'b1;
    bus1.W_addr = 5'd7;
    bus1.Data   = 32'hCAFE0001;
    bus1.A_addr = 5'd7;
    bus1.B_addr = 5'd0;
    sb_push("byp1_a_data", 32'hCAFE0001);
    sb_push("byp1_a_busy", 32'd0);
    sb_push("byp0_a_data", 32'h11111111);
    sb_push("byp0_a_busy", 32'd1);
    sb_push("byp0_stall", 32'd1);
    @(negedge CLK);
    sb_check(bus1.A_data);
    sb_check(32'(bus1.A_busy));
    sb_check(bus0.A_data);
    sb_check(32'(bus0.A_busy));
    sb_check(32'(bus0.stall));
    tick();
    idle();
    sb_push("byp1_after", 32'hCAFE0001);
    sb_push("byp0_after", 32'hCAFE0001);
    sb_push("byp0_busy_after", 32'd0);
    @(negedge CLK);
    sb_check(bus1.A_data);
    sb_check(bus0.A_data);
    sb_check(32'(bus0.A_busy));
    tick();

    // Scoreboard: issue x9
    bus1.issue_en   = 1'b1;
    bus1.issue_addr = 5'd9;
    bus1.A_addr     = 5'd9;
    sb_push("iss9_before", 32'd0);
    @(negedge CLK);
    sb_check(32'(bus1.A_busy));
    tick();
    idle();
    sb_push("iss9_busy", 32'd1);
    sb_push("iss9_stall", 32'd1);
    @(negedge CLK);
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus1.stall));
    tick();

    // Writeback x9
    bus1.wreg   = 1'b1;
    bus1.W_addr = 5'd9;
    bus1.Data   = 32'h00000099;
    sb_push("wb9_busy_byp", 32'd0);
    sb_push("wb9_stall_byp", 32'd0);
    sb_push("wb9_busy_nobyp", 32'd1);
    @(negedge CLK);
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus1.stall));
    sb_check(32'(bus0.A_busy));
    tick();
    idle();
    sb_push("wb9_after_byp", 32'd0);
    sb_push("wb9_after_nobyp", 32'd0);
    @(negedge CLK);
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus0.A_busy));
    tick();

    // Issue and writeback x9 together: set wins
    bus1.wreg       = 1'b1;
    bus1.W_addr     = 5'd9;
    bus1.Data       = 32'h0000009A;
    bus1.issue_en   = 1'b1;
    bus1.issue_addr = 5'd9;
    tick();
    idle();
    bus1.issue_en   = 1'b1;
    bus1.issue_addr = 5'd3;
    bus1.B_addr     = 5'd9;
    sb_push("setwin_a", 32'd1);
    sb_push("setwin_b", 32'd1);
    sb_push("setwin_data", 32'h0000009A);
    @(negedge CLK);
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus1.B_busy));
    sb_check(bus1.A_data);
    tick();
    idle();

    // Reset in RUN with busy bits set
    RESET       = 1'b1;
    bus1.A_addr = 5'd9;
    bus1.B_addr = 5'd3;
    tick();
    RESET = 1'b0;
    sb_push("rrun_ready", 32'd0);
    sb_push("rrun_a_busy", 32'd0);
    sb_push("rrun_b_busy", 32'd0);
    sb_push("rrun_stall", 32'd1);
    @(negedge CLK);
    sb_check(32'(bus1.ready));
    sb_check(32'(bus1.A_busy));
    sb_check(32'(bus1.B_busy));
    sb_check(32'(bus1.stall));
    @(posedge CLK);
    #1;

    // Reset at clear cycle 10, then writes/issues during CLEAR are ignored
    repeat (9) tick();
    RESET = 1'b1;
    tick();
    RESET           = 1'b0;
    bus1.wreg       = 1'b1;
    bus1.W_addr     = 5'd12;
    bus1.Data       = 32'hFFFFFFFF;
    bus1.issue_en   = 1'b1;
    bus1.issue_addr = 5'd12;
    sb_push("midclr_cycles", 32'd31);
    sb_push("midclr_stall", 32'd0);
    wait_ready(cyc, stall_bad);
    idle();
    sb_check(32'(cyc));
    sb_check(32'(stall_bad));
    bus1.A_addr = 5'd12;
    bus1.B_addr = 5'd5;
    sb_push("ign_a_data", 32'd0);
    sb_push("ign_a_busy", 32'd0);
    sb_push("recl_x5", 32'd0);
    sb_push("ign_stall", 32'd0);
    #1;
    sb_check(bus1.A_data);
    sb_check(32'(bus1.A_busy));
    sb_check(bus1.B_data);
    sb_check(32'(bus1.stall));
    tick();
    bus1.A_addr = 5'd7;
    bus1.B_addr = 5'd9;
    sb_push("recl_x7", 32'd0);
    sb_push("recl_x9", 32'd0);
    @(negedge CLK);
    sb_check(bus1.A_data);
    sb_check(bus1.B_data);
    tick();

    sb_push("sb_drained", 32'd0);
    sb_check(32'(sb_q.size() - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
